// File: rtl/cci_mpf_wr_arb_pkg.sv
// Shared types and helpers for the c1 write arbiter and its round-robin core.
// The tag layout here is also how the response path decodes c1Rx mdata.
package cci_mpf_wr_arb_pkg;

  localparam int N_REQ_MAX = 16;
  localparam int CL_ADDR_W = 42;
  localparam int CL_DATA_W = 512;
  localparam int MDATA_W   = 16;
  localparam int TAG_IDX_W = $clog2(N_REQ_MAX);

  typedef logic [MDATA_W-1:0]   t_cci_mdata;
  typedef logic [CL_ADDR_W-1:0] t_ccip_clAddr;
  typedef logic [CL_DATA_W-1:0] t_ccip_clData;

  // Client index sits in the low mdata bits so responses route with a plain slice.
  typedef struct packed {
    logic [MDATA_W-TAG_IDX_W-1:0] rsvd;
    logic [TAG_IDX_W-1:0]         idx;
  } t_wr_arb_tag;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic t_cci_mdata gen_wr_tag(input logic [TAG_IDX_W-1:0] idx);
    t_wr_arb_tag tag;
    tag.rsvd = '0;
    tag.idx  = idx;
    return t_cci_mdata'(tag);
  endfunction

endpackage

// File: rtl/cci_mpf_rr_arb.sv
// Generic N-way round-robin arbiter; search starts at ptr, which moves past
// the winner only when the caller reports that the grant was consumed.
module cci_mpf_rr_arb
  import cci_mpf_wr_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     request,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && request[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/cci_mpf_c1_wr_arb.sv
// Shares the CCI-P c1 write channel among N_REQ clients: round-robin grant,
// one-cycle staging register, per-client outstanding counts and response demux.
module cci_mpf_c1_wr_arb
  import cci_mpf_wr_arb_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [N_REQ-1:0]                    req_valid,
  input  logic [N_REQ-1:0][CL_ADDR_W-1:0]     req_addr,
  input  logic [N_REQ-1:0][CL_DATA_W-1:0]     req_data,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic                                c1TxAlmFull,
  output logic                                c1Tx_valid,
  output logic [CL_ADDR_W-1:0]                c1Tx_addr,
  output logic [CL_DATA_W-1:0]                c1Tx_data,
  output logic [MDATA_W-1:0]                  c1Tx_mdata,
  input  logic                                c1Rx_wrRspValid,
  input  logic [MDATA_W-1:0]                  c1Rx_mdata,
  output logic [N_REQ-1:0]                    rsp_valid,
  output logic [N_REQ-1:0]                    busy,
  output logic                                all_idle,
  output logic                                err_underflow
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [N_REQ-1:0][CNT_W-1:0] cnt;
  logic [N_REQ-1:0]            eligible;
  logic [IDX_W-1:0]            gnt_idx;
  logic                        xfer;
  logic [IDX_W-1:0]            rsp_idx;
  logic [N_REQ-1:0]            rsp_hit;
  logic                        rsp_bad;
  logic                        unused_rsp_tag;

  // Stage p0: eligibility and grant (combinational)
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && !c1TxAlmFull &&
                    (cnt[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  cci_mpf_rr_arb #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .request   (eligible),
    .advance   (xfer),
    .grant     (req_ready),
    .grant_idx (gnt_idx)
  );

  // Eligibility already includes req_valid, so any grant is a transfer.
  assign xfer = |req_ready;

  // Tags outside 0..N_REQ-1 or aimed at an idle client never match a hit.
  assign rsp_idx        = c1Rx_mdata[IDX_W-1:0];
  assign unused_rsp_tag = ^c1Rx_mdata[MDATA_W-1:IDX_W];

  always_comb begin
    rsp_hit = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_hit[i] = c1Rx_wrRspValid && (rsp_idx == IDX_W'(i)) && (cnt[i] != '0);
    end
  end

  assign rsp_bad = c1Rx_wrRspValid && !(|rsp_hit);

  // Stage p1: staged c1 request, routed response pulse, counts and error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c1Tx_valid <= 1'b0;
      c1Tx_addr  <= '0;
      c1Tx_data  <= '0;
      c1Tx_mdata <= '0;
    end else begin
      c1Tx_valid <= xfer;
      if (xfer) begin
        c1Tx_addr  <= req_addr[gnt_idx];
        c1Tx_data  <= req_data[gnt_idx];
        c1Tx_mdata <= gen_wr_tag(TAG_IDX_W'(gnt_idx));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      rsp_valid     <= '0;
      err_underflow <= 1'b0;
    end else begin
      rsp_valid <= rsp_hit;
      if (rsp_bad) begin
        err_underflow <= 1'b1;
      end
      // Grant and response in the same cycle cancel out.
      for (int i = 0; i < N_REQ; i++) begin
        cnt[i] <= cnt[i] + CNT_W'(req_ready[i]) - CNT_W'(rsp_hit[i]);
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < N_REQ; i++) begin
      busy[i] = (cnt[i] != '0);
    end
  end

  assign all_idle = !c1Tx_valid && !(|busy);

endmodule
